// File: rtl/dmem_arbiter_pkg.sv
// Shared state encoding and default parameters for the data-memory arbiter.
package dmem_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_DBG  = 1'b1
  } arb_state_e;

  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_DBG_AW       = 16;
  localparam int DEF_STARVE_LIMIT = 8;

  function automatic int cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating count of cycles a debug request has waited behind the core.
// hit flags that the next increment reaches the forced-grant threshold.
module dmem_arbiter_starve_counter
  import dmem_arbiter_pkg::*;
#(
  parameter int LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  localparam int            CW      = cnt_width(LIMIT);
  localparam logic [CW-1:0] SAT_VAL = CW'(LIMIT);
  localparam logic [CW-1:0] HIT_VAL = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

  always_comb begin
    cnt_inc = (cnt_q == SAT_VAL) ? cnt_q : cnt_q + 1'b1;
    hit     = (cnt_inc >= HIT_VAL);
    cnt_d   = cnt_q;
    if (clr)      cnt_d = '0;
    else if (inc) cnt_d = cnt_inc;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core M stage and a debug port.
//   state    | meaning
//   ARB_IDLE | core owns memory; debug request waits or is counted
//   ARB_DBG  | one-cycle debug access; a core access this cycle is stalled
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int DBG_AW       = DEF_DBG_AW,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_en,
  input  logic                  cpu_we,
  input  logic [31:0]           cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [DBG_AW-1:0]     dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  arb_state_e            state_q, state_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  cnt_clr, cnt_inc, cnt_hit;
  logic                  in_dbg;

  dmem_arbiter_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .hit   (cnt_hit)
  );

  assign in_dbg = (state_q == ARB_DBG);

  always_comb begin
    state_d = ARB_IDLE;
    cnt_clr = 1'b1;
    cnt_inc = 1'b0;
    if (state_q == ARB_IDLE && dbg_req) begin
      if (!cpu_en) begin
        state_d = ARB_DBG;
      end else begin
        cnt_clr = 1'b0;
        cnt_inc = 1'b1;
        if (cnt_hit) begin
          state_d = ARB_DBG;
          cnt_clr = 1'b1;
        end
      end
    end
  end

  // A request withdrawn during the debug slot performs no access.
  assign dbg_gnt   = in_dbg && dbg_req && !reset;
  assign cpu_stall = in_dbg && cpu_en && !reset;
  assign mem_we    = !reset && (in_dbg ? (dbg_gnt && dbg_we) : cpu_we);
  assign mem_addr  = in_dbg ? 32'(dbg_addr) : cpu_addr;
  assign mem_wdata = in_dbg ? dbg_wdata : cpu_wdata;
  assign cpu_rdata = mem_rdata;

  always_comb begin
    rvalid_d = dbg_gnt && !dbg_we;
    rdata_d  = rvalid_d ? mem_rdata : rdata_q;
  end

  assign dbg_rvalid = rvalid_q;
  assign dbg_rdata  = rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural async-read data memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_en, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dbg_req, dbg_we;
  logic [15:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:255];
  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.DATA_WIDTH(32), .DBG_AW(16), .STARVE_LIMIT(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_en     (cpu_en),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; cpu_en = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    tick(); tick();
    #2;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
    checks++; if (dbg_gnt !== 1'b0 || dbg_rvalid !== 1'b0) begin errors++; $display("FAIL reset_pulses got gnt=%b rvalid=%b exp 0/0", dbg_gnt, dbg_rvalid); end
    checks++; if (dbg_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", dbg_rdata); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", cpu_stall); end
    reset = 1'b0; cpu_en = 1'b0; cpu_we = 1'b0;
    tick();
  endtask

  task automatic test_idle_read();
    mem[4] = 32'hCAFE0001;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0010;
    #2;
    checks++; if (dbg_gnt !== 1'b0) begin errors++; $display("FAIL rd_gnt_early got %b exp 0", dbg_gnt); end
    tick(); #2;
    checks++; if (dbg_gnt !== 1'b1 || mem_addr !== 32'h10) begin errors++; $display("FAIL rd_gnt got gnt=%b addr=%h exp 1/00000010", dbg_gnt, mem_addr); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL rd_stall got %b exp 0", cpu_stall); end
    tick(); dbg_req = 1'b0; #2;
    checks++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'hCAFE0001) begin errors++; $display("FAIL rd_data got rv=%b d=%h exp 1/cafe0001", dbg_rvalid, dbg_rdata); end
    checks++; if (dbg_gnt !== 1'b0 || cpu_stall !== 1'b0) begin errors++; $display("FAIL rd_after got gnt=%b stall=%b exp 0/0", dbg_gnt, cpu_stall); end
    tick(); #2;
    checks++; if (dbg_rvalid !== 1'b0 || dbg_rdata !== 32'hCAFE0001) begin errors++; $display("FAIL rd_hold got rv=%b d=%h exp 0/cafe0001", dbg_rvalid, dbg_rdata); end
    tick();
  endtask

  task automatic test_forced_write();
    int gcyc;
    gcyc = 0;
    mem[16] = 32'h12345678; mem[8] = 32'h0;
    cpu_en = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h0020; dbg_wdata = 32'h55;
    for (int c = 1; c <= 20 && gcyc == 0; c++) begin
      #2;
      checks++; if (cpu_stall !== dbg_gnt) begin errors++; $display("FAIL fw_stall_c%0d got %b exp %b", c, cpu_stall, dbg_gnt); end
      if (dbg_gnt === 1'b1) begin
        gcyc = c;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h20) begin errors++; $display("FAIL fw_mem got we=%b addr=%h exp 1/00000020", mem_we, mem_addr); end
      end else begin
        checks++; if (cpu_rdata !== 32'h12345678) begin errors++; $display("FAIL fw_load_c%0d got %h exp 12345678", c, cpu_rdata); end
      end
      tick();
    end
    dbg_req = 1'b0;
    checks++; if (gcyc != 8) begin errors++; $display("FAIL fw_gnt_cycle got %0d exp 8", gcyc); end
    #2;
    checks++; if (cpu_stall !== 1'b0 || cpu_rdata !== 32'h12345678) begin errors++; $display("FAIL fw_replay got stall=%b d=%h exp 0/12345678", cpu_stall, cpu_rdata); end
    checks++; if (mem[8] !== 32'h55) begin errors++; $display("FAIL fw_mem_word got %h exp 00000055", mem[8]); end
    checks++; if (dbg_rvalid !== 1'b0) begin errors++; $display("FAIL fw_rvalid got %b exp 0", dbg_rvalid); end
    tick();
  endtask

  task automatic test_forced_store();
    mem[12] = 32'h0; mem[0] = 32'h11110000;
    cpu_en = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0000;
    for (int c = 1; c <= 7; c++) begin
      #2;
      checks++; if (dbg_gnt !== 1'b0) begin errors++; $display("FAIL st_wait_c%0d got gnt=%b exp 0", c, dbg_gnt); end
      tick();
    end
    cpu_we = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'hAA;
    #2;
    checks++; if (dbg_gnt !== 1'b1 || cpu_stall !== 1'b1) begin errors++; $display("FAIL st_dbg got gnt=%b stall=%b exp 1/1", dbg_gnt, cpu_stall); end
    checks++; if (mem_we !== 1'b0 || mem_addr !== 32'h0) begin errors++; $display("FAIL st_suppress got we=%b addr=%h exp 0/00000000", mem_we, mem_addr); end
    tick();
    checks++; if (mem[12] !== 32'h0) begin errors++; $display("FAIL st_not_yet got %h exp 00000000", mem[12]); end
    dbg_req = 1'b0;
    #2;
    checks++; if (cpu_stall !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 32'h30) begin errors++; $display("FAIL st_replay got stall=%b we=%b addr=%h exp 0/1/00000030", cpu_stall, mem_we, mem_addr); end
    checks++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'h11110000) begin errors++; $display("FAIL st_rdata got rv=%b d=%h exp 1/11110000", dbg_rvalid, dbg_rdata); end
    tick();
    checks++; if (mem[12] !== 32'hAA) begin errors++; $display("FAIL st_landed got %h exp 000000aa", mem[12]); end
    cpu_en = 1'b0; cpu_we = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int n_gnt, n_rv;
    int gcyc [3];
    logic [31:0] exp_d [3];
    n_gnt = 0; n_rv = 0;
    exp_d[0] = 32'hA0; exp_d[1] = 32'hA1; exp_d[2] = 32'hA2;
    mem[0] = 32'hA0; mem[1] = 32'hA1; mem[2] = 32'hA2;
    cpu_en = 1'b0; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0;
    for (int c = 1; c <= 14 && n_rv < 3; c++) begin
      #2;
      if (dbg_rvalid === 1'b1) begin
        checks++; if (dbg_rdata !== exp_d[n_rv]) begin errors++; $display("FAIL b2b_data%0d got %h exp %h", n_rv, dbg_rdata, exp_d[n_rv]); end
        n_rv++;
      end
      if (dbg_gnt === 1'b1 && n_gnt < 3) begin
        gcyc[n_gnt] = c;
        n_gnt++;
      end
      tick();
      if (n_gnt == 3) dbg_req = 1'b0;
      else            dbg_addr = 16'(n_gnt * 4);
    end
    dbg_req = 1'b0;
    checks++; if (n_gnt != 3 || n_rv != 3) begin errors++; $display("FAIL b2b_count got gnt=%0d rv=%0d exp 3/3", n_gnt, n_rv); end
    checks++; if (n_gnt == 3 && (gcyc[0] != 2 || gcyc[1] != 4 || gcyc[2] != 6)) begin errors++; $display("FAIL b2b_spacing got %0d,%0d,%0d exp 2,4,6", gcyc[0], gcyc[1], gcyc[2]); end
    tick();
  endtask

  task automatic test_abort_and_reset();
    int early;
    early = 0;
    mem[20] = 32'h0;
    cpu_en = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h0050; dbg_wdata = 32'h99;
    for (int c = 1; c <= 9; c++) begin
      if (c == 6) dbg_req = 1'b0;
      #2;
      if (dbg_gnt !== 1'b0) early++;
      tick();
    end
    checks++; if (early != 0) begin errors++; $display("FAIL ab_no_gnt got %0d grants exp 0", early); end
    dbg_req = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      #2;
      checks++; if (dbg_gnt !== 1'b0) begin errors++; $display("FAIL ab_restart_c%0d got gnt=%b exp 0", c, dbg_gnt); end
      tick();
    end
    reset = 1'b1;
    #2;
    checks++; if (dbg_gnt !== 1'b0 || mem_we !== 1'b0 || cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_dbg got gnt=%b we=%b stall=%b exp 0/0/0", dbg_gnt, mem_we, cpu_stall); end
    tick();
    reset = 1'b0; dbg_req = 1'b0; cpu_en = 1'b0;
    #2;
    checks++; if (dbg_rvalid !== 1'b0 || dbg_rdata !== 32'h0 || dbg_gnt !== 1'b0) begin errors++; $display("FAIL rst_after got rv=%b d=%h gnt=%b exp 0/00000000/0", dbg_rvalid, dbg_rdata, dbg_gnt); end
    checks++; if (mem[20] !== 32'h0) begin errors++; $display("FAIL rst_mem got %h exp 00000000", mem[20]); end
    tick();
  endtask

  task automatic test_addr_ext();
    mem[255] = 32'h0;
    cpu_en = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h12340008;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'hFFFC; dbg_wdata = 32'h77;
    #2;
    checks++; if (mem_addr !== 32'h12340008) begin errors++; $display("FAIL ext_core_mux got %h exp 12340008", mem_addr); end
    tick(); #2;
    checks++; if (dbg_gnt !== 1'b1 || mem_addr !== 32'h0000FFFC) begin errors++; $display("FAIL ext_addr got gnt=%b addr=%h exp 1/0000fffc", dbg_gnt, mem_addr); end
    checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'h77) begin errors++; $display("FAIL ext_wdata got we=%b d=%h exp 1/00000077", mem_we, mem_wdata); end
    tick();
    dbg_req = 1'b0;
    checks++; if (mem[255] !== 32'h77) begin errors++; $display("FAIL ext_mem got %h exp 00000077", mem[255]); end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    test_reset();
    test_idle_read();
    test_forced_write();
    test_forced_store();
    test_back_to_back();
    test_abort_and_reset();
    test_addr_ext();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
